// File: rtl/sram_bank_arbiter.sv
// ============================================================================
// Module      : sram_bank_arbiter
// Description : Arbitrates a CPU port and a management Wishbone port onto the
//               shared macro bus of NBANKS SRAM word banks, with a 1-cycle read path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_arbiter #(
  parameter int NBANKS  = 4,
  parameter int BANK_AW = 9,
  parameter int DW      = 16,
  parameter int RR_MODE = 0,
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int AW = BANK_AW + BW,
  localparam int NB = DW / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic                 cpu_gnt,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_rvalid,
  input  logic                 wb_req,
  input  logic                 wb_we,
  input  logic [NB-1:0]        wb_sel,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_wdata,
  output logic [DW-1:0]        wb_rdata,
  output logic                 wb_ack,
  output logic [NBANKS-1:0]    mem_cenb,
  output logic                 mem_gwenb,
  output logic [DW-1:0]        mem_wenb,
  output logic [BANK_AW-1:0]   mem_a,
  output logic [DW-1:0]        mem_d,
  input  logic [NBANKS*DW-1:0] mem_q
);

  localparam logic [BW:0] c_nbanks = (BW+1)'(NBANKS);

  logic               r_last_wb;
  logic               r_cpu_rvalid;
  logic               r_wb_ack;
  logic               r_wb_rd;
  logic [BW-1:0]      r_bank;
  logic               r_bank_ok;
  logic [BANK_AW-1:0] r_mem_a;
  logic [DW-1:0]      r_mem_d;
  logic [DW-1:0]      r_cpu_rdata;
  logic [DW-1:0]      r_wb_rdata;

  logic               w_wb_elig;
  logic               w_gnt_cpu;
  logic               w_gnt_wb;
  logic               w_gnt;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_wdata;
  logic [BW-1:0]      w_bank;
  logic               w_bank_ok;
  logic [DW-1:0]      w_qsel;

  // A WB request is ineligible during its own ack cycle, which caps WB at one access per two cycles
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_wb  = 1'b0;
    w_wb_elig = wb_req & ~r_wb_ack;
    if (!rst) begin
      if (RR_MODE == 0) begin
        w_gnt_cpu = cpu_req;
        w_gnt_wb  = w_wb_elig & ~cpu_req;
      end else if (cpu_req && w_wb_elig) begin
        w_gnt_cpu = r_last_wb;
        w_gnt_wb  = ~r_last_wb;
      end else begin
        w_gnt_cpu = cpu_req;
        w_gnt_wb  = w_wb_elig;
      end
    end
  end

  assign w_gnt     = w_gnt_cpu | w_gnt_wb;
  assign w_we      = w_gnt_wb ? wb_we    : cpu_we;
  assign w_addr    = w_gnt_wb ? wb_addr  : cpu_addr;
  assign w_wdata   = w_gnt_wb ? wb_wdata : cpu_wdata;
  assign w_bank    = w_addr[AW-1:BANK_AW];
  assign w_bank_ok = ({1'b0, w_bank} < c_nbanks);

  always_comb begin
    mem_cenb  = '1;
    mem_gwenb = 1'b1;
    mem_wenb  = '1;
    mem_a     = r_mem_a;
    mem_d     = r_mem_d;
    if (w_gnt) begin
      mem_a     = w_addr[BANK_AW-1:0];
      mem_d     = w_wdata;
      mem_gwenb = ~w_we;
      for (int k = 0; k < NBANKS; k++) begin
        if (w_bank == BW'(k)) mem_cenb[k] = 1'b0;
      end
      if (w_we) begin
        if (w_gnt_cpu) begin
          mem_wenb = '0;
        end else begin
          for (int i = 0; i < NB; i++) mem_wenb[i*8 +: 8] = {8{~wb_sel[i]}};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_wb    <= 1'b1;
      r_cpu_rvalid <= 1'b0;
      r_wb_ack     <= 1'b0;
      r_wb_rd      <= 1'b0;
      r_bank       <= '0;
      r_bank_ok    <= 1'b0;
      r_mem_a      <= '0;
      r_mem_d      <= '0;
    end else begin
      r_cpu_rvalid <= w_gnt_cpu & ~cpu_we;
      r_wb_ack     <= w_gnt_wb;
      r_wb_rd      <= w_gnt_wb & ~wb_we;
      if (w_gnt) begin
        r_last_wb <= w_gnt_wb;
        r_bank    <= w_bank;
        r_bank_ok <= w_bank_ok;
        r_mem_a   <= w_addr[BANK_AW-1:0];
        r_mem_d   <= w_wdata;
      end
    end
  end

  // Macro outputs arrive one cycle after the access; out-of-range banks read as zero
  always_comb begin
    w_qsel = '0;
    for (int k = 0; k < NBANKS; k++) begin
      if (r_bank == BW'(k)) w_qsel = mem_q[k*DW +: DW];
    end
    if (!r_bank_ok) w_qsel = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rdata <= '0;
      r_wb_rdata  <= '0;
    end else begin
      if (r_cpu_rvalid)        r_cpu_rdata <= w_qsel;
      if (r_wb_ack && r_wb_rd) r_wb_rdata  <= w_qsel;
    end
  end

  assign cpu_gnt    = w_gnt_cpu;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? w_qsel : r_cpu_rdata;
  assign wb_ack     = r_wb_ack;
  assign wb_rdata   = (r_wb_ack && r_wb_rd) ? w_qsel : r_wb_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_bank_arbiter.sv
// ============================================================================
// Module      : tb_sram_bank_arbiter
// Description : Directed bench; three arbiter variants share one stimulus bus,
//               each backed by a behavioural SRAM macro model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, wb_req, wb_we;
  logic [10:0] cpu_addr, wb_addr;
  logic [15:0] cpu_wdata, wb_wdata;
  logic [1:0]  wb_sel;

  logic        a_cpu_gnt, a_cpu_rvalid, a_wb_ack, a_mem_gwenb;
  logic [15:0] a_cpu_rdata, a_wb_rdata, a_mem_wenb, a_mem_d;
  logic [3:0]  a_mem_cenb;
  logic [8:0]  a_mem_a;
  logic [63:0] a_mem_q;

  logic        b_cpu_gnt, b_cpu_rvalid, b_wb_ack, b_mem_gwenb;
  logic [15:0] b_cpu_rdata, b_wb_rdata, b_mem_wenb, b_mem_d;
  logic [3:0]  b_mem_cenb;
  logic [8:0]  b_mem_a;
  logic [63:0] b_mem_q;

  logic        c_cpu_gnt, c_cpu_rvalid, c_wb_ack, c_mem_gwenb;
  logic [15:0] c_cpu_rdata, c_wb_rdata, c_mem_wenb, c_mem_d;
  logic [2:0]  c_mem_cenb;
  logic [8:0]  c_mem_a;
  logic [47:0] c_mem_q;

  logic [15:0] ma [0:3][0:511];
  logic [15:0] mb [0:3][0:511];
  logic [15:0] mc [0:2][0:511];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sram_bank_arbiter #(.NBANKS(4), .BANK_AW(9), .DW(16), .RR_MODE(0)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
    .wb_req(wb_req), .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(a_wb_rdata), .wb_ack(a_wb_ack),
    .mem_cenb(a_mem_cenb), .mem_gwenb(a_mem_gwenb), .mem_wenb(a_mem_wenb),
    .mem_a(a_mem_a), .mem_d(a_mem_d), .mem_q(a_mem_q)
  );

  sram_bank_arbiter #(.NBANKS(4), .BANK_AW(9), .DW(16), .RR_MODE(1)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .wb_req(wb_req), .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(b_wb_rdata), .wb_ack(b_wb_ack),
    .mem_cenb(b_mem_cenb), .mem_gwenb(b_mem_gwenb), .mem_wenb(b_mem_wenb),
    .mem_a(b_mem_a), .mem_d(b_mem_d), .mem_q(b_mem_q)
  );

  sram_bank_arbiter #(.NBANKS(3), .BANK_AW(9), .DW(16), .RR_MODE(0)) u_c (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(c_cpu_gnt), .cpu_rdata(c_cpu_rdata), .cpu_rvalid(c_cpu_rvalid),
    .wb_req(wb_req), .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(c_wb_rdata), .wb_ack(c_wb_ack),
    .mem_cenb(c_mem_cenb), .mem_gwenb(c_mem_gwenb), .mem_wenb(c_mem_wenb),
    .mem_a(c_mem_a), .mem_d(c_mem_d), .mem_q(c_mem_q)
  );

  // Macro model: per-bit masked write, registered read output that holds between reads
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!a_mem_cenb[k]) begin
        if (!a_mem_gwenb) ma[k][a_mem_a] <= (ma[k][a_mem_a] & a_mem_wenb) | (a_mem_d & ~a_mem_wenb);
        else              a_mem_q[k*16 +: 16] <= ma[k][a_mem_a];
      end
      if (!b_mem_cenb[k]) begin
        if (!b_mem_gwenb) mb[k][b_mem_a] <= (mb[k][b_mem_a] & b_mem_wenb) | (b_mem_d & ~b_mem_wenb);
        else              b_mem_q[k*16 +: 16] <= mb[k][b_mem_a];
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!c_mem_cenb[k]) begin
        if (!c_mem_gwenb) mc[k][c_mem_a] <= (mc[k][c_mem_a] & c_mem_wenb) | (c_mem_d & ~c_mem_wenb);
        else              c_mem_q[k*16 +: 16] <= mc[k][c_mem_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    wb_req = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_addr = '0; wb_wdata = '0;
    step(); step();
    rst = 1'b0;
    step();

    // CPU write 0xBEEF to 0x205 (bank 1) then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h205; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_gnt",   a_cpu_gnt,   1);
    chk("wr_cenb",  a_mem_cenb,  4'b1101);
    chk("wr_gwenb", a_mem_gwenb, 0);
    chk("wr_wenb",  a_mem_wenb,  16'h0000);
    chk("wr_a",     a_mem_a,     9'h005);
    chk("wr_d",     a_mem_d,     16'hBEEF);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("rd_cenb",  a_mem_cenb,  4'b1101);
    chk("rd_gwenb", a_mem_gwenb, 1);
    chk("rd_wenb",  a_mem_wenb,  16'hFFFF);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", a_cpu_rvalid, 1);
    chk("rd_rdata",  a_cpu_rdata,  16'hBEEF);
    chk("idle_cenb", a_mem_cenb,   4'hF);
    chk("idle_a",    a_mem_a,      9'h005);
    step();
    @(negedge clk);
    chk("rvalid_drop", a_cpu_rvalid, 0);
    chk("rdata_hold",  a_cpu_rdata,  16'hBEEF);

    // Asynchronous reset pulse between clock edges, with a CPU request pending
    #1; rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    chk("ar_gnt",    a_cpu_gnt,    0);
    chk("ar_cenb",   a_mem_cenb,   4'hF);
    chk("ar_gwenb",  a_mem_gwenb,  1);
    chk("ar_wenb",   a_mem_wenb,   16'hFFFF);
    chk("ar_a",      a_mem_a,      0);
    chk("ar_d",      a_mem_d,      0);
    chk("ar_rvalid", a_cpu_rvalid, 0);
    chk("ar_ack",    a_wb_ack,     0);
    chk("ar_crdata", a_cpu_rdata,  0);
    chk("ar_wrdata", a_wb_rdata,   0);
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step();

    // WB byte write of upper lane onto 0xBEEF, then held read requests
    wb_req = 1'b1; wb_we = 1'b1; wb_sel = 2'b10; wb_addr = 11'h205; wb_wdata = 16'h12AB;
    @(negedge clk);
    chk("wbw_cenb",  a_mem_cenb,  4'b1101);
    chk("wbw_wenb",  a_mem_wenb,  16'h00FF);
    chk("wbw_gwenb", a_mem_gwenb, 0);
    chk("wbw_cgnt",  a_cpu_gnt,   0);
    step();
    @(negedge clk);
    chk("wbw_ack",   a_wb_ack,   1);
    chk("wbw_nogrant", a_mem_cenb, 4'hF);
    step();
    wb_we = 1'b0;
    @(negedge clk);
    chk("wbr_ack0",  a_wb_ack,    0);
    chk("wbr_cenb",  a_mem_cenb,  4'b1101);
    chk("wbr_gwenb", a_mem_gwenb, 1);
    step();
    @(negedge clk);
    chk("wbr_ack1",  a_wb_ack,   1);
    chk("wbr_rdata", a_wb_rdata, 16'h12EF);
    step();
    @(negedge clk);
    chk("wbh_ack0",  a_wb_ack,   0);
    chk("wbh_cenb",  a_mem_cenb, 4'b1101);
    step();
    @(negedge clk);
    chk("wbh_ack1",  a_wb_ack,   1);
    step();
    @(negedge clk);
    chk("wbh_ack2",  a_wb_ack,   0);
    step();
    wb_req = 1'b0;
    @(negedge clk);
    chk("wbh_ack3",  a_wb_ack,   1);
    step();

    // Out-of-range bank on the 3-bank variant: 0x600 selects bank 3
    wb_req = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_addr = 11'h600; wb_wdata = 16'h5555;
    @(negedge clk);
    chk("oor_w_cenb",  c_mem_cenb, 3'b111);
    chk("oor_w_cenb4", a_mem_cenb, 4'b0111);
    step();
    @(negedge clk);
    chk("oor_w_ack", c_wb_ack, 1);
    step();
    wb_we = 1'b0;
    @(negedge clk);
    chk("oor_r_cenb", c_mem_cenb, 3'b111);
    step();
    @(negedge clk);
    chk("oor_r_ack",   c_wb_ack,   1);
    chk("oor_r_rdata", c_wb_rdata, 16'h0000);
    chk("inr_r_rdata", a_wb_rdata, 16'h5555);
    step();
    wb_req = 1'b0;

    // Contention after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h205;
    wb_req = 1'b1; wb_we = 1'b0; wb_addr = 11'h005;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fix_cgnt", a_cpu_gnt, 1);
      chk("fix_ack",  a_wb_ack,  0);
      chk("rr_cgnt",  b_cpu_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_cenb",  b_mem_cenb, (i % 2 == 0) ? 4'b1101 : 4'b1110);
      step();
    end
    cpu_req = 1'b0; wb_req = 1'b0;
    step(); step();

    // Reset in the cycle after a CPU read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h205;
    @(negedge clk);
    chk("rg_gnt", a_cpu_gnt, 1);
    step();
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rg_rvalid0", a_cpu_rvalid, 0);
    @(negedge clk);
    chk("rg_rvalid1", a_cpu_rvalid, 0);
    rst = 1'b0;
    step();
    cpu_req = 1'b1;
    @(negedge clk);
    chk("post_gnt", a_cpu_gnt, 1);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("post_rvalid", a_cpu_rvalid, 1);
    chk("post_rdata",  a_cpu_rdata,  16'h12EF);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
